// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: data widths, reset vector and the
// {pc, instr} record that travels from fetch to decode.
package riscv_pkg;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned ILEN     = 32;
   localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_unit_sync_fifo.sv
// Generic synchronous FIFO with first-word fall-through read and a
// single-cycle flush. Push while full is accepted only alongside a pop.
module sync_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));
   assign count = count_q;
   assign rdata = mem_q[rd_ptr_q];

   assign do_pop  = pop & ~empty;
   assign do_push = push & ~flush & (~full | do_pop);

   // Next-state for storage, pointers and occupancy; flush overrides everything
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, reads instruction memory
// combinationally and buffers {pc, instr} pairs for decode. A redirect
// flushes the buffer and restarts fetch at the (word-aligned) target.
module riscv_fetch_unit
   import riscv_pkg::*;
#(
   parameter int unsigned     XLEN       = riscv_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC   = riscv_pkg::RESET_PC,
   parameter int unsigned     FIFO_DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   output logic [XLEN-1:0]  imem_addr_o,
   input  logic [31:0]      imem_rdata_i,
   input  logic             redirect_i,
   input  logic [XLEN-1:0]  redirect_pc_i,
   output logic             instr_valid_o,
   output logic [31:0]      instr_o,
   output logic [XLEN-1:0]  instr_pc_o,
   input  logic             instr_ready_i
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic            push, pop;
   fetch_entry_t    wr_entry, rd_entry;
   logic            fifo_empty;
   logic            fifo_full_unused;
   logic [CW-1:0]   fifo_count;

   assign imem_addr_o   = {fetch_pc_q[XLEN-1:2], 2'b00};
   assign instr_valid_o = ~fifo_empty;
   assign instr_o       = instr_valid_o ? rd_entry.instr : '0;
   assign instr_pc_o    = instr_valid_o ? rd_entry.pc    : '0;

   assign pop  = instr_valid_o & instr_ready_i;
   assign push = ~redirect_i & ((fifo_count < CW'(FIFO_DEPTH)) | pop);

   assign wr_entry.pc    = fetch_pc_q;
   assign wr_entry.instr = imem_rdata_i;

   // Fetch PC: redirect target takes precedence, otherwise advance on push
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      if (redirect_i) begin
         fetch_pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
      end else if (push) begin
         fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
   end

   // Fetch PC register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fetch_pc_q <= RESET_PC;
      end else begin
         fetch_pc_q <= fetch_pc_d;
      end
   end

   sync_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_prefetch (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .push  (push),
      .pop   (pop),
      .flush (redirect_i),
      .wdata (wr_entry),
      .rdata (rd_entry),
      .full  (fifo_full_unused),
      .empty (fifo_empty),
      .count (fifo_count)
   );

endmodule

// File: doc/riscv_fetch_unit.md
Name: riscv_fetch_unit

Overview:
Instruction fetch stage sitting directly upstream of riscv_core decode. It owns the fetch PC and drives the instruction memory address. It buffers fetched {pc, instr} pairs in a small prefetch FIFO and presents them to decode over a valid/ready handshake. A control-flow redirect from the core flushes the buffer and restarts fetch at the new PC.

Parameters:
XLEN, 32, address/PC width
RESET_PC, 32'h0000_0000, first fetch address after reset
FIFO_DEPTH, 4, prefetch entries; power of 2, >= 2

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  synchronous reset, active-high
imem_addr_o  output  XLEN  instruction memory address (= fetch PC)
imem_rdata_i  input  32  instruction word; combinational read of imem_addr_o, valid in the same cycle
redirect_i  input  1  flush and restart fetch (branch/jump taken)
redirect_pc_i  input  XLEN  restart address; bits [1:0] ignored
instr_valid_o  output  1  FIFO head holds a valid entry
instr_o  output  32  instruction at FIFO head
instr_pc_o  output  XLEN  PC of instr_o
instr_ready_i  input  1  decode accepts the head this cycle

Behaviour:
- Interface: one clock (clk_i); reset is synchronous and active-high (rst_i).
- Reset (rst_i=1 at a rising edge) has priority over all other inputs. It sets fetch_pc=RESET_PC, empties the FIFO, and forces instr_valid_o=0.
  - instr_o and instr_pc_o are don't-care while invalid; the implementation drives 0.
  - Reset asserted mid-stream discards all buffered entries with no further handshakes.
- imem_addr_o = {fetch_pc[XLEN-1:2], 2'b00}, purely combinational from the fetch_pc register.
- pop = instr_valid_o & instr_ready_i.
- push = !redirect_i & (count < FIFO_DEPTH | pop).
  - Full FIFO with a simultaneous pop still pushes.
  - On push: write {fetch_pc, imem_rdata_i} to the tail and set fetch_pc <= fetch_pc + 4.
  - The +4 wraps modulo 2^XLEN (0xFFFF_FFFC -> 0x0).
- No push: fetch_pc holds.
- Redirect (redirect_i=1, no reset):
  - FIFO count goes to 0 and no push occurs.
  - fetch_pc <= {redirect_pc_i[XLEN-1:2], 2'b00}.
  - A pop in the same cycle still counts as accepted by decode; the flush discards everything else.
  - instr_valid_o=0 in the following cycle. The redirect target appears at the head two cycles after the redirect edge.
- Latency:
  - Fetch to valid at head is 1 cycle: pushed at edge N, visible at head after edge N.
  - First instruction after reset release: instr_valid_o=1 one cycle after the first non-reset edge.
- Throughput: 1 instruction/cycle sustained while instr_ready_i=1.
- Ordering: strict program order between redirects. Entries are never duplicated or dropped except by flush.
- Stall: instr_ready_i=0 fills the FIFO to FIFO_DEPTH, then fetch_pc freezes. instr_o and instr_pc_o remain stable while valid & !ready.
- No state machine beyond fetch_pc and the FIFO pointers/count.
  - Pointers wrap naturally at FIFO_DEPTH.
  - count is $clog2(FIFO_DEPTH)+1 bits.

Decomposition:
- riscv_pkg holds:
  - XLEN default
  - ILEN=32
  - RESET_PC default
  - typedef struct packed {logic [XLEN-1:0] pc; logic [ILEN-1:0] instr;} fetch_entry_t
- One sub-module: sync_fifo, a generic synchronous FIFO with:
  - parameters WIDTH, DEPTH
  - ports push, pop, flush, full, empty, count, wdata, rdata
  - first-word fall-through read
- riscv_fetch_unit instantiates sync_fifo with WIDTH=$bits(fetch_entry_t).
- sync_fifo has the same clock/reset convention.

Test Plan:
- Reset then streaming: rst_i=1 for 2 cycles, then instr_ready_i=1 with imem = word(addr)=addr^32'hA5A5_0000 -> handshakes in order with pc 0x0,0x4,0x8,0xC…, each instr matches, one per cycle starting 1 cycle after reset release.
- Backpressure: instr_ready_i=0 for 10 cycles after reset -> count saturates at 4, imem_addr_o freezes at 0x10, head stays pc=0x0. Then ready=1 -> pc 0x0,0x4,0x8,0xC,0x10,0x14 with no gaps or duplicates.
- Full + pop: FIFO full, ready=1 for one cycle -> head advances to pc=0x4 and pc=0x10 is pushed in the same cycle, count stays 4.
- Redirect: while streaming at pc 0x20, redirect_i=1 with redirect_pc_i=0x0000_1003 and ready=1 -> pc 0x20 accepted that cycle, valid=0 the next cycle, then pc 0x1000, 0x1004…
- Wrap and reset mid-operation: redirect to 0xFFFF_FFF8 -> pcs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0. Then rst_i=1 with a 3-entry FIFO -> valid=0 next cycle and fetch restarts at RESET_PC.
- Redirect with reset together: rst_i=1 and redirect_i=1 with redirect_pc_i=0x40 -> reset wins, first fetched pc after release is RESET_PC.
